// File: rtl/cfg_frame_loader.sv
// Byte-serial configuration loader for logic_switch: assembles a frame into a
// shadow register, checks its trailing checksum and only then commits it to prog.
module cfg_frame_loader #(
  parameter  int PROG_W = 176,
  localparam int NBYTES = PROG_W / 8,
  localparam int CNT_W  = $clog2(NBYTES + 1)
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              cfg_start,
  input  logic [7:0]        cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [PROG_W-1:0] prog,
  output logic              prog_upd,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CKSUM = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [PROG_W-1:0]  shadow;
  logic [7:0]         sum;
  logic [7:0]         sum_next;
  logic               accept;

  // Handshake: a byte transfers on a rising edge where cfg_valid and cfg_ready
  // are both high. cfg_ready depends only on state and cfg_start (never on
  // cfg_valid), and drops whenever cfg_start is high so a restart wins over a byte.
  assign cfg_ready = (state != IDLE) && !cfg_start;
  assign accept    = cfg_valid && cfg_ready;
  assign sum_next  = sum + cfg_data;

  assign dbg_state = state;
  assign dbg_count = count;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state    <= IDLE;
      count    <= '0;
      shadow   <= '0;
      sum      <= '0;
      prog     <= '0;
      prog_upd <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      prog_upd <= 1'b0;
      if (cfg_start) begin
        // Start and restart look identical; prog keeps its committed value.
        state    <= LOAD;
        count    <= '0;
        shadow   <= '0;
        sum      <= '0;
        cfg_done <= 1'b0;
        cfg_err  <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              shadow <= {shadow[PROG_W-9:0], cfg_data};
              sum    <= sum_next;
              count  <= count + CNT_W'(1);
              if (count == CNT_W'(NBYTES - 1)) begin
                state <= CKSUM;
              end
            end
          end
          CKSUM: begin
            if (accept) begin
              if (sum_next == 8'h00) begin
                prog     <= shadow;
                cfg_done <= 1'b1;
                prog_upd <= 1'b1;
              end else begin
                cfg_err  <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed plus randomized bench for cfg_frame_loader against a queue-based
// frame model: accepted bytes are collected whole and judged once complete.
module tb_cfg_frame_loader;

  localparam int PROG_W = 176;
  localparam int NBYTES = PROG_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  logic              clk;
  logic              nres;
  logic              cfg_start;
  logic [7:0]        cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [PROG_W-1:0] prog;
  logic              prog_upd;
  logic              cfg_done;
  logic              cfg_err;
  logic [1:0]        dbg_state;
  logic [CNT_W-1:0]  dbg_count;

  cfg_frame_loader #(.PROG_W(PROG_W)) dut (
    .clk       (clk),
    .nres      (nres),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .prog      (prog),
    .prog_upd  (prog_upd),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and model ----------------
  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  always @(posedge clk) begin
    if (nres && cfg_valid && cfg_ready) hs_count++;
  end

  bit                model_active;
  logic [7:0]        frame_q[$];
  logic [PROG_W-1:0] exp_prog;
  logic              exp_done;
  logic              exp_err;
  logic              exp_upd;

  logic [7:0] frame1 [NBYTES] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h69, 8'h69,
                                  8'h80, 8'h80, 8'h40, 8'h40, 8'h20, 8'h20,
                                  8'h10, 8'h10, 8'h08, 8'h08, 8'h04, 8'h04,
                                  8'h02, 8'h02, 8'h01, 8'h01};
  localparam logic [PROG_W-1:0] FRAME1_PROG =
    176'hFFFF0000696980804040202010100808040402020101;

  task automatic chk(input string tag, input logic [PROG_W-1:0] obs,
                     input logic [PROG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_active = 1'b0;
    frame_q.delete();
    exp_prog = '0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_upd  = 1'b0;
  endtask

  // Judge a complete frame: byte 0 lands in the top byte of prog.
  task automatic model_finish_frame();
    int s;
    logic [PROG_W-1:0] p;
    s = 0;
    p = '0;
    foreach (frame_q[i]) s += int'(frame_q[i]);
    for (int i = 0; i < NBYTES; i++) p[PROG_W-1-8*i -: 8] = frame_q[i];
    if (s % 256 == 0) begin
      exp_prog = p;
      exp_done = 1'b1;
      exp_upd  = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    model_active = 1'b0;
  endtask

  task automatic check_regs();
    logic [1:0] es;
    int ec;
    es = !model_active ? 2'd0 : (frame_q.size() < NBYTES ? 2'd1 : 2'd2);
    ec = frame_q.size() > NBYTES ? NBYTES : frame_q.size();
    chk("prog", prog, exp_prog);
    chk("prog_upd", PROG_W'(prog_upd), PROG_W'(exp_upd));
    chk("cfg_done", PROG_W'(cfg_done), PROG_W'(exp_done));
    chk("cfg_err", PROG_W'(cfg_err), PROG_W'(exp_err));
    chk("state", PROG_W'(dbg_state), PROG_W'(es));
    chk("count", PROG_W'(dbg_count), PROG_W'(ec));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit start, input bit valid, input logic [7:0] data);
    bit exp_ready;
    @(negedge clk);
    cfg_start = start;
    cfg_valid = valid;
    cfg_data  = data;
    #1;
    exp_ready = model_active && !start;
    chk("cfg_ready", PROG_W'(cfg_ready), PROG_W'(exp_ready));
    exp_upd = 1'b0;
    if (start) begin
      model_active = 1'b1;
      frame_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
    end else if (valid && exp_ready) begin
      frame_q.push_back(data);
      if (frame_q.size() == NBYTES + 1) model_finish_frame();
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] ck,
                            input int max_gap);
    logic [7:0] all_q[$];
    all_q = pl;
    all_q.push_back(ck);
    cycle(1'b1, 1'b1, 8'($urandom));
    foreach (all_q[i]) begin
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, 1'b0, 8'($urandom));
      cycle(1'b0, 1'b1, all_q[i]);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    #2;
    nres = 1'b0;
    #1;
    model_reset();
    chk("rst_prog", prog, '0);
    chk("rst_ready", PROG_W'(cfg_ready), '0);
    chk("rst_done", PROG_W'(cfg_done), '0);
    chk("rst_err", PROG_W'(cfg_err), '0);
    chk("rst_upd", PROG_W'(prog_upd), '0);
    chk("rst_state", PROG_W'(dbg_state), '0);
    chk("rst_count", PROG_W'(dbg_count), '0);
    @(negedge clk);
    nres = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] f1_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] zero_q[$];
    logic [7:0] ck;
    int hs_before;
    int s;

    foreach (frame1[i]) f1_q.push_back(frame1[i]);
    for (int i = 0; i < NBYTES; i++) zero_q.push_back(8'h00);

    nres      = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs();
    chk("rst_ready0", PROG_W'(cfg_ready), '0);
    @(negedge clk);
    nres = 1'b1;
    idle_cycles(2);

    // 1: good frame, no gaps
    send_frame(f1_q, 8'h32, 0);
    chk("frame1_prog", prog, FRAME1_PROG);
    chk("frame1_done", PROG_W'(cfg_done), PROG_W'(1));
    idle_cycles(2);

    // 2: bad checksum keeps prior prog
    send_frame(f1_q, 8'h33, 0);
    chk("bad_err", PROG_W'(cfg_err), PROG_W'(1));
    chk("bad_prog", prog, FRAME1_PROG);
    idle_cycles(2);

    // 3: gaps of 0-3 cycles
    async_reset();
    hs_before = hs_count;
    send_frame(f1_q, 8'h32, 3);
    chk("gap_prog", prog, FRAME1_PROG);
    chk("gap_handshakes", PROG_W'(hs_count - hs_before), PROG_W'(NBYTES + 1));
    idle_cycles(2);

    // 4: abort after 10 bytes, then all-zero frame
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'hAA);
    chk("abort_prog_hold", prog, FRAME1_PROG);
    cycle(1'b1, 1'b1, 8'hAA);
    chk("abort_no_err", PROG_W'(cfg_err), '0);
    foreach (zero_q[i]) cycle(1'b0, 1'b1, zero_q[i]);
    chk("zero_prog_hold", prog, FRAME1_PROG);
    cycle(1'b0, 1'b1, 8'h00);
    chk("zero_prog", prog, '0);
    idle_cycles(2);

    // 5: reset after 15 bytes, then full frame
    send_frame(f1_q, 8'h32, 0);
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, frame1[i]);
    async_reset();
    send_frame(f1_q, 8'h32, 1);
    chk("post_rst_prog", prog, FRAME1_PROG);

    // 6: bytes offered in IDLE are ignored
    hs_before = hs_count;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h55);
    chk("idle_no_accept", PROG_W'(hs_count - hs_before), '0);

    // randomized frames, good and bad checksums
    for (int f = 0; f < 12; f++) begin
      pl_q.delete();
      s = 0;
      for (int i = 0; i < NBYTES; i++) begin
        pl_q.push_back(8'($urandom));
        s += int'(pl_q[i]);
      end
      ck = 8'(256 - (s % 256));
      if ($urandom_range(0, 2) == 0) ck = ck + 8'($urandom_range(1, 255));
      send_frame(pl_q, ck, $urandom_range(0, 2));
      idle_cycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
